pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It covers three cases: load-use interlock, control redirects resolved in MEM (jump/jump-register/branch), and multi-cycle data-memory waits with a watchdog. It also keeps saturating stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/sat_counter.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned RegAw   = 5;
    localparam int unsigned ZeroReg = 0;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StErr
    } state_e;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } stage_en_t;

    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic ex_mem;
    } stage_flush_t;

    function automatic stage_en_t all_en(input logic v);
        return '{pc: v, if_id: v, id_ex: v, ex_mem: v, mem_wb: v};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, MEM-stage
// redirects and data-memory waits with a watchdog, plus stall/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = RegAw,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic              ex_memread_i,
    input  logic              ex_regwrite_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              redirect_mem_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic              pc_en_o,
    output logic              pc_redirect_o,
    output logic              if_id_en_o,
    output logic              id_ex_en_o,
    output logic              ex_mem_en_o,
    output logic              mem_wb_en_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              ex_mem_flush_o,
    output logic              mem_wb_bubble_o,
    output logic              mem_timeout_err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT) + 1;

    state_e       state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic         err_q, err_d;

    stage_en_t    en;
    stage_flush_t flush;
    logic         bubble;
    logic         redirect;
    logic         stall_inc;
    logic         flush_inc;

    logic mem_stall;
    logic rs_hit;
    logic rt_hit;
    logic load_use;

    assign mem_stall = mem_req_i & ~mem_ready_i;
    assign rs_hit    = id_uses_rs_i & (id_rs_i == ex_rd_i);
    assign rt_hit    = id_uses_rt_i & (id_rt_i == ex_rd_i);
    assign load_use  = ex_memread_i & ex_regwrite_i & (ex_rd_i != REG_AW'(ZeroReg)) &
                       (rs_hit | rt_hit);

    always_comb begin
        en         = all_en(1'b1);
        flush      = '0;
        bubble     = 1'b0;
        redirect   = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        state_d    = state_q;
        wait_cnt_d = '0;
        err_d      = err_q;

        if (reset_i) begin
            en      = all_en(1'b0);
            flush   = '1;
            bubble  = 1'b1;
            state_d = StRun;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                StRun, StMemWait: begin
                    if (mem_stall) begin
                        // Upstream is frozen, so redirect/load-use re-present next cycle.
                        en         = all_en(1'b0);
                        bubble     = 1'b1;
                        stall_inc  = 1'b1;
                        wait_cnt_d = wait_cnt_q + WaitW'(1);
                        if ((state_q == StMemWait) &&
                            (wait_cnt_q == WaitW'(MEM_TIMEOUT - 1))) begin
                            state_d = StErr;
                            err_d   = 1'b1;
                        end else begin
                            state_d = StMemWait;
                        end
                    end else begin
                        state_d = StRun;
                        if (redirect_mem_i) begin
                            redirect  = 1'b1;
                            flush     = '1;
                            flush_inc = 1'b1;
                        end else if (load_use) begin
                            en.pc       = 1'b0;
                            en.if_id    = 1'b0;
                            flush.id_ex = 1'b1;
                            stall_inc   = 1'b1;
                        end
                    end
                end
                StErr: begin
                    en     = all_en(1'b0);
                    bubble = 1'b1;
                    err_d  = 1'b1;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (stall_inc),
        .count_o (stall_cnt_o)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc_i   (flush_inc),
        .count_o (flush_cnt_o)
    );

    assign pc_en_o           = en.pc;
    assign if_id_en_o        = en.if_id;
    assign id_ex_en_o        = en.id_ex;
    assign ex_mem_en_o       = en.ex_mem;
    assign mem_wb_en_o       = en.mem_wb;
    assign if_id_flush_o     = flush.if_id;
    assign id_ex_flush_o     = flush.id_ex;
    assign ex_mem_flush_o    = flush.ex_mem;
    assign mem_wb_bubble_o   = bubble;
    assign pc_redirect_o     = redirect;
    assign mem_timeout_err_o = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second CNT_W=4 instance covers saturation.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, ex_memread, ex_regwrite;
    logic       redirect_mem, mem_req, mem_ready;

    logic        pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_bubble, err;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_pc_redirect, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
    logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_bubble, s_err;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    logic [4:0] en_v;
    logic [2:0] fl_v;
    assign en_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl_v = {if_id_flush, id_ex_flush, ex_mem_flush};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk_i (clk), .reset_i (reset),
        .id_rs_i (id_rs), .id_rt_i (id_rt),
        .id_uses_rs_i (id_uses_rs), .id_uses_rt_i (id_uses_rt),
        .ex_memread_i (ex_memread), .ex_regwrite_i (ex_regwrite), .ex_rd_i (ex_rd),
        .redirect_mem_i (redirect_mem), .mem_req_i (mem_req), .mem_ready_i (mem_ready),
        .pc_en_o (pc_en), .pc_redirect_o (pc_redirect),
        .if_id_en_o (if_id_en), .id_ex_en_o (id_ex_en),
        .ex_mem_en_o (ex_mem_en), .mem_wb_en_o (mem_wb_en),
        .if_id_flush_o (if_id_flush), .id_ex_flush_o (id_ex_flush),
        .ex_mem_flush_o (ex_mem_flush), .mem_wb_bubble_o (mem_wb_bubble),
        .mem_timeout_err_o (err), .stall_cnt_o (stall_cnt), .flush_cnt_o (flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(16), .CNT_W(4)) dut_small (
        .clk_i (clk), .reset_i (reset),
        .id_rs_i (id_rs), .id_rt_i (id_rt),
        .id_uses_rs_i (id_uses_rs), .id_uses_rt_i (id_uses_rt),
        .ex_memread_i (ex_memread), .ex_regwrite_i (ex_regwrite), .ex_rd_i (ex_rd),
        .redirect_mem_i (redirect_mem), .mem_req_i (mem_req), .mem_ready_i (mem_ready),
        .pc_en_o (s_pc_en), .pc_redirect_o (s_pc_redirect),
        .if_id_en_o (s_if_id_en), .id_ex_en_o (s_id_ex_en),
        .ex_mem_en_o (s_ex_mem_en), .mem_wb_en_o (s_mem_wb_en),
        .if_id_flush_o (s_if_id_flush), .id_ex_flush_o (s_id_ex_flush),
        .ex_mem_flush_o (s_ex_mem_flush), .mem_wb_bubble_o (s_mem_wb_bubble),
        .mem_timeout_err_o (s_err), .stall_cnt_o (s_stall_cnt), .flush_cnt_o (s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_regwrite = 1'b0;
        redirect_mem = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = rd;
        id_uses_rs = 1'b1; id_rs = rd;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        chk("rst_en", 32'(en_v), 32'h00);
        chk("rst_flush", 32'(fl_v), 32'h7);
        chk("rst_bubble", 32'(mem_wb_bubble), 32'h1);
        chk("rst_redirect", 32'(pc_redirect), 32'h0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("idle_en", 32'(en_v), 32'h1f);
        chk("idle_flush", 32'(fl_v), 32'h0);
        chk("idle_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("idle_flush_cnt", 32'(flush_cnt), 32'h0);
        chk("idle_err", 32'(err), 32'h0);

        // Load-use on rs
        set_load_use(5'd8);
        #1;
        chk("lu_en", 32'(en_v), 32'h07);
        chk("lu_flush", 32'(fl_v), 32'h2);
        chk("lu_bubble", 32'(mem_wb_bubble), 32'h0);
        tick();
        ex_memread = 1'b0;
        #1;
        chk("lu_after_en", 32'(en_v), 32'h1f);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        // ex_rd = $zero never interlocks
        set_load_use(5'd0);
        #1;
        chk("lu_r0_en", 32'(en_v), 32'h1f);
        tick();
        chk("lu_r0_stall_cnt", 32'(stall_cnt), 32'd1);
        // Match on rs but rs unused: no hazard
        set_load_use(5'd5);
        id_uses_rs = 1'b0;
        #1;
        chk("lu_rs_unused_en", 32'(en_v), 32'h1f);
        // Hazard through rt
        id_uses_rt = 1'b1; id_rt = 5'd5;
        #1;
        chk("lu_rt_en", 32'(en_v), 32'h07);
        tick();
        clear_inputs();
        #1;
        chk("lu_rt_stall_cnt", 32'(stall_cnt), 32'd2);

        // Redirect wins over a simultaneous load-use
        set_load_use(5'd8);
        redirect_mem = 1'b1;
        #1;
        chk("rd_en", 32'(en_v), 32'h1f);
        chk("rd_flush", 32'(fl_v), 32'h7);
        chk("rd_redirect", 32'(pc_redirect), 32'h1);
        chk("rd_bubble", 32'(mem_wb_bubble), 32'h0);
        tick();
        clear_inputs();
        #1;
        chk("rd_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("rd_stall_cnt", 32'(stall_cnt), 32'd2);

        // Three-cycle memory wait
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_en", 32'(en_v), 32'h00);
            chk("mw_bubble", 32'(mem_wb_bubble), 32'h1);
            chk("mw_flush", 32'(fl_v), 32'h0);
            tick();
            chk("mw_state", 32'(dut.state_q), 32'(StMemWait));
        end
        mem_ready = 1'b1;
        #1;
        chk("mw_rel_en", 32'(en_v), 32'h1f);
        chk("mw_rel_bubble", 32'(mem_wb_bubble), 32'h0);
        tick();
        clear_inputs();
        #1;
        chk("mw_rel_state", 32'(dut.state_q), 32'(StRun));
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd5);

        // Memory stall masks a pending redirect until release
        mem_req = 1'b1; mem_ready = 1'b0; redirect_mem = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("sp_flush", 32'(fl_v), 32'h0);
            chk("sp_redirect", 32'(pc_redirect), 32'h0);
            chk("sp_en", 32'(en_v), 32'h00);
            tick();
        end
        chk("sp_flush_cnt_hold", 32'(flush_cnt), 32'd1);
        mem_ready = 1'b1;
        #1;
        chk("sp_rel_flush", 32'(fl_v), 32'h7);
        chk("sp_rel_redirect", 32'(pc_redirect), 32'h1);
        chk("sp_rel_en", 32'(en_v), 32'h1f);
        tick();
        clear_inputs();
        #1;
        chk("sp_flush_cnt", 32'(flush_cnt), 32'd2);
        chk("sp_stall_cnt", 32'(stall_cnt), 32'd7);

        // Watchdog: 16 stalled cycles then ERR
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("wd_err_low", 32'(err), 32'h0);
            chk("wd_en", 32'(en_v), 32'h00);
            tick();
        end
        chk("wd_err", 32'(err), 32'h1);
        chk("wd_state", 32'(dut.state_q), 32'(StErr));
        chk("wd_stall_cnt", 32'(stall_cnt), 32'd23);
        mem_req = 1'b0; redirect_mem = 1'b1;
        #1;
        chk("err_en", 32'(en_v), 32'h00);
        chk("err_bubble", 32'(mem_wb_bubble), 32'h1);
        chk("err_redirect", 32'(pc_redirect), 32'h0);
        tick();
        chk("err_sticky", 32'(err), 32'h1);
        chk("err_stall_hold", 32'(stall_cnt), 32'd23);
        chk("err_flush_hold", 32'(flush_cnt), 32'd2);
        clear_inputs();
        reset = 1'b1;
        #1;
        chk("err_rst_flush", 32'(fl_v), 32'h7);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_err", 32'(err), 32'h0);
        chk("post_rst_state", 32'(dut.state_q), 32'(StRun));
        chk("post_rst_stall", 32'(stall_cnt), 32'd0);
        chk("post_rst_flush", 32'(flush_cnt), 32'd0);
        chk("post_rst_en", 32'(en_v), 32'h1f);

        // Saturation: 20 load-use stall cycles
        set_load_use(5'd3);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) chk("sat_at_15", 32'(s_stall_cnt), 32'd15);
        end
        clear_inputs();
        #1;
        chk("sat_small", 32'(s_stall_cnt), 32'd15);
        chk("sat_big", 32'(stall_cnt), 32'd20);
        chk("sat_small_flush", 32'(s_flush_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
